// File: rtl/cpu_pkg.sv
// Purpose: shared types, encodings and helpers for the CPU controller slice.
// Optional feature macro: CPU_CTRL_HALT_EN adds the HALT state and the halted output.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned IMM8_W   = 8;
    localparam int unsigned IMM5_W   = 5;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned OPC_W    = 3;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned SEL_W    = 2;

    // Controller states; HALT exists only in the halt-enabled build
    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
`ifdef CPU_CTRL_HALT_EN
        ,
        ST_HALT      = 3'd7
`endif
    } state_e;

    // Opcode classes
    localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    // Sub-op encodings
    localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0] OP_AND     = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

    // Register-file write-data select
    localparam logic [SEL_W-1:0] VSEL_C     = 2'b00;
    localparam logic [SEL_W-1:0] VSEL_PC    = 2'b01;
    localparam logic [SEL_W-1:0] VSEL_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] VSEL_MDATA = 2'b11;

    // Shifter encodings
    localparam logic [SEL_W-1:0] SH_NONE = 2'b00;
    localparam logic [SEL_W-1:0] SH_LSL  = 2'b01;
    localparam logic [SEL_W-1:0] SH_LSR  = 2'b10;
    localparam logic [SEL_W-1:0] SH_ASR  = 2'b11;

    // ALU operation encodings
    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
    localparam logic [SEL_W-1:0] ALU_MVN = 2'b11;

    // Decoded instruction fields (imm8 is consumed only by the sign extender)
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rd;
        logic [SEL_W-1:0]  shift;
        logic [REG_W-1:0]  rm;
        logic [IMM5_W-1:0] imm5;
    } instr_fields_t;

    // Datapath control bundle
    typedef struct packed {
        logic              w;
        logic [REG_W-1:0]  readnum;
        logic [REG_W-1:0]  writenum;
        logic [SEL_W-1:0]  vsel;
        logic [SEL_W-1:0]  shift;
        logic [SEL_W-1:0]  aluop;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              write;
        logic              asel;
        logic              bsel;
`ifdef CPU_CTRL_HALT_EN
        logic              halted;
`endif
    } ctrl_t;

    function automatic logic [INSTR_W-1:0] sext_imm8(input logic [IMM8_W-1:0] v);
        return {{(INSTR_W-IMM8_W){v[IMM8_W-1]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Purpose: bus between the instruction source / datapath and the controller.
// Ports (signals): s, load, in (towards controller); w, readnum, writenum, vsel,
//   shift, ALUop, loada, loadb, loadc, loads, write, asel, bsel, sximm8, imm5,
//   and halted when CPU_CTRL_HALT_EN is defined (from controller).
interface cpu_controller_if;
    import cpu_pkg::*;

    logic                s;
    logic                load;
    logic [INSTR_W-1:0]  in;
    logic                w;
    logic [REG_W-1:0]    readnum;
    logic [REG_W-1:0]    writenum;
    logic [SEL_W-1:0]    vsel;
    logic [SEL_W-1:0]    shift;
    logic [SEL_W-1:0]    ALUop;
    logic                loada;
    logic                loadb;
    logic                loadc;
    logic                loads;
    logic                write;
    logic                asel;
    logic                bsel;
    logic [INSTR_W-1:0]  sximm8;
    logic [IMM5_W-1:0]   imm5;
`ifdef CPU_CTRL_HALT_EN
    logic                halted;
`endif

    modport master (
`ifdef CPU_CTRL_HALT_EN
        input  halted,
`endif
        output s, load, in,
        input  w, readnum, writenum, vsel, shift, ALUop,
               loada, loadb, loadc, loads, write, asel, bsel, sximm8, imm5
    );

    modport slave (
`ifdef CPU_CTRL_HALT_EN
        output halted,
`endif
        input  s, load, in,
        output w, readnum, writenum, vsel, shift, ALUop,
               loada, loadb, loadc, loads, write, asel, bsel, sximm8, imm5
    );

endinterface

// File: rtl/instr_dec.sv
// Purpose: combinational split of the instruction register into fields plus
//   sign-extended 8-bit immediate.
// Ports: i_ir (instruction word), o_fields_c (decoded fields), o_sximm8_c.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output instr_fields_t      o_fields_c,
    output logic [INSTR_W-1:0] o_sximm8_c
);

    // Field positions are fixed by the instruction format
    always_comb begin
        o_fields_c.opcode = i_ir[15:13];
        o_fields_c.op     = i_ir[12:11];
        o_fields_c.rn     = i_ir[10:8];
        o_fields_c.rd     = i_ir[7:5];
        o_fields_c.shift  = i_ir[4:3];
        o_fields_c.rm     = i_ir[2:0];
        o_fields_c.imm5   = i_ir[4:0];
    end

    assign o_sximm8_c = sext_imm8(i_ir[IMM8_W-1:0]);

endmodule

// File: rtl/cpu_controller.sv
// Purpose: Moore control FSM sequencing register reads, ALU execution and
//   register writes for MOV/ADD/CMP/AND/MVN; holds the instruction register.
// Ports: clk, rst_n (async active-low), bus (cpu_controller_if.slave).
// Optional feature macro: CPU_CTRL_HALT_EN (opcode 111 parks the FSM in HALT
//   until reset and drives bus.halted).
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cpu_controller_if.slave   bus
);

    state_e               r_state;
    state_e               w_next;
    logic [INSTR_W-1:0]   r_ir;
    instr_fields_t        w_fields;
    logic [INSTR_W-1:0]   w_sximm8;
    ctrl_t                w_ctrl;
    logic                 w_is_mov;
    logic                 w_is_alu;
    logic                 w_is_cmp;

    instr_dec u_instr_dec (
        .i_ir       (r_ir),
        .o_fields_c (w_fields),
        .o_sximm8_c (w_sximm8)
    );

    assign w_is_mov = (w_fields.opcode == OPC_MOV);
    assign w_is_alu = (w_fields.opcode == OPC_ALU);
    assign w_is_cmp = w_is_alu && (w_fields.op == OP_CMP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT;
        else        r_state <= w_next;
    end

    // Instruction register: captured only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_ir <= '0;
        else if ((r_state == ST_WAIT) && bus.load) r_ir <= bus.in;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT: begin
                if (bus.s) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                // Undefined encodings fall back to WAIT with no side effects
                w_next = ST_WAIT;
                if (w_is_mov && (w_fields.op == OP_MOV_IMM))      w_next = ST_WRITE_IMM;
                else if (w_is_mov && (w_fields.op == OP_MOV_REG)) w_next = ST_GET_B;
                else if (w_is_alu)                                w_next = (w_fields.op == OP_MVN) ? ST_GET_B : ST_GET_A;
`ifdef CPU_CTRL_HALT_EN
                else if (w_fields.opcode == OPC_HALT)             w_next = ST_HALT;
`endif
            end
            ST_GET_A:     w_next = ST_GET_B;
            ST_GET_B:     w_next = ST_EXEC;
            ST_EXEC:      w_next = w_is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: w_next = ST_WAIT;
            ST_WRITE_IMM: w_next = ST_WAIT;
`ifdef CPU_CTRL_HALT_EN
            ST_HALT:      w_next = ST_HALT;
`endif
            default:      w_next = ST_WAIT;
        endcase
    end

    // Moore outputs: everything not named for a state stays zero
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_WAIT: begin
                w_ctrl.w = 1'b1;
            end
            ST_GET_A: begin
                w_ctrl.readnum = w_fields.rn;
                w_ctrl.loada   = 1'b1;
            end
            ST_GET_B: begin
                w_ctrl.readnum = w_fields.rm;
                w_ctrl.loadb   = 1'b1;
            end
            ST_EXEC: begin
                // MOV reg passes B through the adder with A forced to zero
                w_ctrl.shift = w_fields.shift;
                w_ctrl.aluop = w_is_mov ? ALU_ADD : w_fields.op;
                w_ctrl.asel  = w_is_mov;
                w_ctrl.bsel  = 1'b0;
                if (w_is_cmp) w_ctrl.loads = 1'b1;
                else          w_ctrl.loadc = 1'b1;
            end
            ST_WRITE_REG: begin
                w_ctrl.writenum = w_fields.rd;
                w_ctrl.vsel     = VSEL_C;
                w_ctrl.write    = 1'b1;
            end
            ST_WRITE_IMM: begin
                w_ctrl.writenum = w_fields.rn;
                w_ctrl.vsel     = VSEL_IMM;
                w_ctrl.write    = 1'b1;
            end
`ifdef CPU_CTRL_HALT_EN
            ST_HALT: begin
                w_ctrl.halted = 1'b1;
            end
`endif
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    assign bus.w        = w_ctrl.w;
    assign bus.readnum  = w_ctrl.readnum;
    assign bus.writenum = w_ctrl.writenum;
    assign bus.vsel     = w_ctrl.vsel;
    assign bus.shift    = w_ctrl.shift;
    assign bus.ALUop    = w_ctrl.aluop;
    assign bus.loada    = w_ctrl.loada;
    assign bus.loadb    = w_ctrl.loadb;
    assign bus.loadc    = w_ctrl.loadc;
    assign bus.loads    = w_ctrl.loads;
    assign bus.write    = w_ctrl.write;
    assign bus.asel     = w_ctrl.asel;
    assign bus.bsel     = w_ctrl.bsel;
    assign bus.sximm8   = w_sximm8;
    assign bus.imm5     = w_fields.imm5;
`ifdef CPU_CTRL_HALT_EN
    assign bus.halted   = w_ctrl.halted;
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Purpose: self-checking bench for cpu_controller. A queue-based model expands
//   each started instruction into its list of expected control vectors; a
//   compare process checks every cycle, and directed sequences pin literals.
module tb_cpu_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       halted;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] m_ir = '0;
    exp_t        m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic exp_t idle_rec();
        exp_t r = '0;
        r.w = 1'b1;
        return r;
    endfunction

    // Expand one instruction into its per-cycle expected outputs after s
    function automatic void push_seq(input logic [15:0] ir);
        logic [2:0] opc = ir[15:13];
        logic [1:0] op  = ir[12:11];
        bit   movi = (opc == 3'b110) && (op == 2'b10);
        bit   movr = (opc == 3'b110) && (op == 2'b00);
        bit   alu  = (opc == 3'b101);
        exp_t d = '0;
        exp_t a = '0;
        exp_t b = '0;
        exp_t e = '0;
        exp_t wr = '0;
        exp_t h = '0;
        a.readnum = ir[10:8];  a.loada = 1'b1;
        b.readnum = ir[2:0];   b.loadb = 1'b1;
        e.shift   = ir[4:3];
        e.aluop   = alu ? op : 2'b00;
        e.asel    = movr;
        if (alu && op == 2'b01) e.loads = 1'b1;
        else                    e.loadc = 1'b1;
        wr.writenum = ir[7:5]; wr.write = 1'b1;
        h.halted = 1'b1;
        m_q.push_back(d);
        if (movi) begin
            wr.writenum = ir[10:8];
            wr.vsel     = 2'b10;
            m_q.push_back(wr);
        end else if (movr || (alu && op == 2'b11)) begin
            m_q.push_back(b); m_q.push_back(e); m_q.push_back(wr);
        end else if (alu) begin
            m_q.push_back(a); m_q.push_back(b); m_q.push_back(e);
            if (op != 2'b01) m_q.push_back(wr);
        end
`ifdef CPU_CTRL_HALT_EN
        else if (opc == 3'b111) m_q.push_back(h);
`endif
    endfunction

    // Reference model: advances on clock edges, clears on reset
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ir = '0;
                m_q.delete();
            end else if (m_q.size() == 0) begin
                if (bus.load) m_ir = bus.in;
                if (bus.s) push_seq(m_ir);
            end else if (!m_q[0].halted) begin
                void'(m_q.pop_front());
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        exp_t e;
        exp_t a;
        #3;
        forever begin
            @(negedge clk);
            e = (m_q.size() == 0) ? idle_rec() : m_q[0];
            a.w = bus.w;           a.readnum = bus.readnum; a.writenum = bus.writenum;
            a.vsel = bus.vsel;     a.shift = bus.shift;     a.aluop = bus.ALUop;
            a.loada = bus.loada;   a.loadb = bus.loadb;     a.loadc = bus.loadc;
            a.loads = bus.loads;   a.write = bus.write;     a.asel = bus.asel;
            a.bsel = bus.bsel;
`ifdef CPU_CTRL_HALT_EN
            a.halted = bus.halted;
`else
            a.halted = 1'b0;
`endif
            chk("ctrl_vec", 32'(a), 32'(e));
            chk("sximm8", 32'(bus.sximm8), 32'({{8{m_ir[7]}}, m_ir[7:0]}));
            chk("imm5", 32'(bus.imm5), 32'(m_ir[4:0]));
        end
    end

    // Drive inputs just after a falling edge; literal checks follow the call
    task automatic cyc(input logic s_v, input logic load_v, input logic [15:0] in_v);
        @(negedge clk);
        #1;
        bus.s    = s_v;
        bus.load = load_v;
        bus.in   = in_v;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_w", 32'(bus.w), 32'd1);
        chk("rst_sximm8", 32'(bus.sximm8), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("idle_no_s", 32'(bus.w), 32'd1);

        // MOV R2,#5 with load attempted during DECODE
        cyc(1'b1, 1'b1, 16'hD205);
        cyc(1'b0, 1'b1, 16'h1234);
        chk("movi_decode_w", 32'(bus.w), 32'd0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("movi_wnum", 32'(bus.writenum), 32'd2);
        chk("movi_vsel", 32'(bus.vsel), 32'd2);
        chk("movi_write", 32'(bus.write), 32'd1);
        chk("movi_sx", 32'(bus.sximm8), 32'h0005);
        cyc(1'b0, 1'b0, 16'h0);
        chk("movi_done_w", 32'(bus.w), 32'd1);
        chk("load_ignored", 32'(bus.sximm8), 32'h0005);

        // MOV R0,#-1 with s held high: immediate re-execution
        cyc(1'b1, 1'b1, 16'hD0FF);
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        chk("movn_sx", 32'(bus.sximm8), 32'hFFFF);
        chk("movn_wnum", 32'(bus.writenum), 32'd0);
        cyc(1'b1, 1'b0, 16'h0);
        chk("movn_wait", 32'(bus.w), 32'd1);
        cyc(1'b0, 1'b0, 16'h0);
        chk("movn_redo", 32'(bus.w), 32'd0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);

        // ADD R3,R1,R2 LSL1
        cyc(1'b1, 1'b1, 16'hA16A);
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_decode_w", 32'(bus.w), 32'd0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_geta", 32'({bus.readnum, bus.loada}), 32'({3'd1, 1'b1}));
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_getb", 32'({bus.readnum, bus.loadb}), 32'({3'd2, 1'b1}));
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_exec", 32'({bus.ALUop, bus.shift, bus.loadc, bus.asel}), 32'({2'd0, 2'd1, 1'b1, 1'b0}));
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_wr", 32'({bus.writenum, bus.vsel, bus.write}), 32'({3'd3, 2'd0, 1'b1}));
        cyc(1'b0, 1'b0, 16'h0);
        chk("add_done", 32'(bus.w), 32'd1);

        // CMP R1,R2
        cyc(1'b1, 1'b1, 16'hA902);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("cmp_exec", 32'({bus.ALUop, bus.loads, bus.loadc, bus.write}), 32'({2'd1, 1'b1, 1'b0, 1'b0}));
        cyc(1'b0, 1'b0, 16'h0);
        chk("cmp_done", 32'({bus.w, bus.write}), 32'({1'b1, 1'b0}));

        // Asynchronous reset in the middle of GET_B
        cyc(1'b1, 1'b1, 16'hA16A);
        cyc(1'b0, 1'b1, 16'h5555);
        cyc(1'b0, 1'b1, 16'h5555);
        cyc(1'b0, 1'b0, 16'h0);
        chk("pre_rst_loadb", 32'(bus.loadb), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({bus.w, bus.readnum, bus.loadb}), 32'({1'b1, 3'd0, 1'b0}));
        chk("mid_rst_ir", 32'(bus.sximm8), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Opcode 111: HALT in the halt build, undefined otherwise
        cyc(1'b1, 1'b1, 16'hE000);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'hD205);
`ifdef CPU_CTRL_HALT_EN
        chk("halt_set", 32'({bus.halted, bus.w}), 32'({1'b1, 1'b0}));
`else
        chk("e000_wait", 32'({bus.w, bus.write}), 32'({1'b1, 1'b0}));
`endif
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        do_reset();

        // Randomized traffic biased toward defined encodings
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 5))
                0:       v = {3'b110, 2'b10, 11'($urandom)};
                1:       v = {3'b110, 2'b00, 11'($urandom)};
                2, 3:    v = {3'b101, 13'($urandom)};
                default: v = 16'($urandom);
            endcase
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, v);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        cyc(1'b0, 1'b0, 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
